// File: rtl/io_bus_ctrl_if.sv
// Bus bundle around io_bus_ctrl: master request/response fields and the
// broadcast peripheral-side fields. The controller uses the slave view.
interface io_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLV  = 3
);
  logic                    m_req;
  logic                    m_we;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic [DATA_W/8-1:0]     m_be;
  logic                    m_ack;
  logic                    m_err;
  logic [DATA_W-1:0]       m_rdata;

  logic [N_SLV-1:0]        s_sel;
  logic                    s_we;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [DATA_W/8-1:0]     s_be;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic [N_SLV-1:0]        s_ready;

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_ack, m_err, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_ack, m_err, m_rdata,
    output s_sel, s_we, s_addr, s_wdata, s_be,
    input  s_rdata, s_ready
  );

  modport periph (
    input  s_sel, s_we, s_addr, s_wdata, s_be,
    output s_rdata, s_ready
  );
endinterface

// File: rtl/io_bus_ctrl.sv
// Single-outstanding bus controller: decodes a master request onto one of
// N_SLV slaves, waits for ready or timeout, and returns a one-cycle ack.
module io_bus_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                N_SLV      = 3,
  parameter logic [ADDR_W-13:0] PERIPH_TAG = 20'hFFFFF,
  parameter logic [63:0]       SLV_MAP    = 64'hFFFF_FFFF_22FF_FF11,
  parameter int                TIMEOUT    = 255,
  parameter int                TICK_DIV   = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  io_bus_ctrl_if.slave       bus,
  output logic               dev_tick,
  output logic [7:0]         err_cnt
);
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int TICK_W = $clog2(TICK_DIV);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;
  logic [3:0]        lat_idx;
  logic [CNT_W-1:0]  acc_cnt;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [TICK_W-1:0] tick_cnt;

  logic [3:0]        dec_idx;
  logic              dec_mapped;
  logic [N_SLV-1:0]  sel_vec;
  logic [DATA_W-1:0] sel_rdata;
  logic              ready_hit;
  logic              timeout_hit;
  logic              err_event;

  // Non-peripheral addresses always go to main memory on slave 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    dec_idx = 4'd0;
    if (bus.m_addr[ADDR_W-1:12] == PERIPH_TAG)
      dec_idx = SLV_MAP[int'(bus.m_addr[7:4]) * 4 +: 4];
    dec_mapped = (dec_idx != 4'hF) && (int'(dec_idx) < N_SLV);
  end

  always_comb begin
    sel_vec   = '0;
    sel_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (lat_idx == 4'(k)) begin
        sel_vec[k] = 1'b1;
        sel_rdata  = bus.s_rdata[k*DATA_W +: DATA_W];
      end
    end
    if (state != ACCESS) sel_vec = '0;
    ready_hit   = |(sel_vec & bus.s_ready);
    timeout_hit = (state == ACCESS) && !ready_hit && (acc_cnt == CNT_W'(TIMEOUT));
    err_event   = ((state == IDLE) && bus.m_req && !dec_mapped) || timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_idx    <= 4'd0;
      acc_cnt    <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_req) begin
            lat_we    <= bus.m_we;
            lat_addr  <= bus.m_addr;
            lat_wdata <= bus.m_wdata;
            lat_be    <= bus.m_be;
            lat_idx   <= dec_idx;
            acc_cnt   <= CNT_W'(1);
            if (dec_mapped) begin
              state <= ACCESS;
            end else begin
              state      <= RESP;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (ready_hit) begin
            state      <= RESP;
            resp_err   <= 1'b0;
            resp_rdata <= lat_we ? '0 : sel_rdata;
          end else if (timeout_hit) begin
            state      <= RESP;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            acc_cnt <= acc_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err_event && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign dev_tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));

  assign bus.m_ack   = (state == RESP);
  assign bus.m_err   = resp_err;
  assign bus.m_rdata = resp_rdata;
  assign bus.s_sel   = sel_vec;
  assign bus.s_we    = lat_we;
  assign bus.s_addr  = lat_addr;
  assign bus.s_wdata = lat_wdata;
  assign bus.s_be    = lat_be;
endmodule
